// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_arbiter
// Description : Shares a single data-memory port between instruction fetch
//               (IF) and the EX-stage LSU. One transaction is outstanding at
//               a time: IDLE accepts a request, REQ presents it to memory,
//               RESP routes the reply back to its owner. A watchdog turns a
//               missing reply into an error response.
//               Optional feature macro: CORE_MEM_ARB_RR_EN selects
//               round-robin arbitration; otherwise the LSU has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module core_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    // instruction-fetch request/response
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    output logic                if_rsp_err,
    // load/store unit request/response
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                lsu_rsp_err,
    // shared memory bus
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    input  logic                mem_rsp_err,
    // status
    output logic                busy
);

    localparam int c_mask_w = DATA_W / 8;
    localparam int c_tmr_w  = $clog2(RSP_TIMEOUT + 1);

    // Last timer value allowed before the watchdog forces an error response
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(RSP_TIMEOUT - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_max  = {c_tmr_w{1'b1}};

    localparam logic c_own_if  = 1'b0;
    localparam logic c_own_lsu = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_owner;
    logic [c_tmr_w-1:0]   r_timer;
    logic                 r_mem_req_valid;
    logic [ADDR_W-1:0]    r_mem_req_addr;
    logic                 r_mem_req_wen;
    logic [DATA_W-1:0]    r_mem_req_wdata;
    logic [c_mask_w-1:0]  r_mem_req_wmask;

    logic                 w_grant_if;
    logic                 w_grant_lsu;
    logic                 w_idle;
    logic                 w_in_resp;
    logic                 w_timeout;
    logic                 w_rsp_fire;
    logic [DATA_W-1:0]    w_rsp_data;
    logic                 w_rsp_err;

`ifdef CORE_MEM_ARB_RR_EN
    // Owner granted most recently; on a tie the other requester wins
    logic r_rr_last;

    // Round-robin grant: a lone requester always wins
    always_comb begin
        w_grant_lsu = lsu_req_valid && (!if_req_valid || (r_rr_last == c_own_if));
        w_grant_if  = if_req_valid && !w_grant_lsu;
    end

    // Pointer follows every accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last <= c_own_if;
        end else if (if_req_ready || lsu_req_ready) begin
            r_rr_last <= lsu_req_ready ? c_own_lsu : c_own_if;
        end
    end
`else
    // Fixed priority grant: LSU always beats IF
    always_comb begin
        w_grant_lsu = lsu_req_valid;
        w_grant_if  = if_req_valid && !lsu_req_valid;
    end
`endif

    // Handshake and response routing; all qualified by reset so nothing leaks
    // out of a transaction that is being abandoned
    always_comb begin
        w_idle        = (r_state == S_IDLE) && !rst;
        w_in_resp     = (r_state == S_RESP) && !rst;
        if_req_ready  = w_idle && w_grant_if;
        lsu_req_ready = w_idle && w_grant_lsu;
        w_timeout     = w_in_resp && !mem_rsp_valid && (r_timer == c_tmr_last);
        w_rsp_fire    = w_in_resp && (mem_rsp_valid || w_timeout);
        w_rsp_data    = mem_rsp_valid ? mem_rsp_data : '0;
        w_rsp_err     = mem_rsp_valid ? mem_rsp_err : 1'b1;
        if_rsp_valid  = w_rsp_fire && (r_owner == c_own_if);
        lsu_rsp_valid = w_rsp_fire && (r_owner == c_own_lsu);
        if_rsp_data   = w_rsp_data;
        if_rsp_err    = w_rsp_err;
        lsu_rsp_data  = w_rsp_data;
        lsu_rsp_err   = w_rsp_err;
    end

    // Transaction FSM: capture request, hold it on the bus, wait for reply
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_owner         <= c_own_if;
            r_timer         <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_req_wen   <= 1'b0;
            r_mem_req_wdata <= '0;
            r_mem_req_wmask <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (lsu_req_ready) begin
                        r_owner         <= c_own_lsu;
                        r_mem_req_addr  <= lsu_req_addr;
                        r_mem_req_wen   <= lsu_req_wen;
                        r_mem_req_wdata <= lsu_req_wdata;
                        r_mem_req_wmask <= lsu_req_wmask;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= S_REQ;
                    end else if (if_req_ready) begin
                        r_owner         <= c_own_if;
                        r_mem_req_addr  <= if_req_addr;
                        r_mem_req_wen   <= 1'b0;
                        r_mem_req_wdata <= '0;
                        r_mem_req_wmask <= '0;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Replies arriving before the request is taken are strays
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_timer         <= '0;
                        r_state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_rsp_fire) begin
                        r_state <= S_IDLE;
                    end else if (r_timer != c_tmr_max) begin
                        r_timer <= r_timer + c_tmr_w'(1);
                    end
                end
                default: begin
                    r_state         <= S_IDLE;
                    r_mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_addr  = r_mem_req_addr;
    assign mem_req_wen   = r_mem_req_wen;
    assign mem_req_wdata = r_mem_req_wdata;
    assign mem_req_wmask = r_mem_req_wmask;
    assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_mem_arbiter
// Description : Scoreboard bench for core_mem_arbiter. Expected memory
//               requests and owner responses are queued when stimulus is
//               issued and compared as the design produces them. A small
//               scripted memory model answers requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mem_arbiter;

    localparam int c_tmo = 4;
    localparam logic [31:0] c_pat = 32'h5A5A_0000;

    logic        clk;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
    logic [3:0]  lsu_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
    logic [3:0]  mem_req_wmask;
    logic        busy;

    core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RSP_TIMEOUT(c_tmo)) u_dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .busy(busy)
    );

    typedef struct {
        bit          lsu;
        logic [31:0] data;
        bit          err;
        int          lat;
        bit          cmp_data;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        bit          wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        bit          cmp_wdata;
    } req_t;

    rsp_t exp_rsp_q[$];
    req_t exp_req_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;

    // memory model controls
    int          cfg_ready_wait = 0;
    int          cfg_rsp_wait   = 0;
    bit          cfg_no_rsp     = 0;
    bit          cfg_fixed_en   = 0;
    bit          cfg_rsp_err    = 0;
    logic [31:0] cfg_rsp_data   = 32'h0;
    int          stray_cnt      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ c_pat;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void push_rsp(input bit lsu, input logic [31:0] d, input bit e,
                                     input int lat, input bit cmp);
        rsp_t r;
        r.lsu = lsu; r.data = d; r.err = e; r.lat = lat; r.cmp_data = cmp;
        exp_rsp_q.push_back(r);
    endfunction

    function automatic void push_req(input logic [31:0] a, input bit w, input logic [31:0] d,
                                     input logic [3:0] m, input bit cmp);
        req_t r;
        r.addr = a; r.wen = w; r.wdata = d; r.wmask = m; r.cmp_wdata = cmp;
        exp_req_q.push_back(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scripted memory: waits cfg_ready_wait cycles before taking a request,
    // then replies cfg_rsp_wait cycles into RESP (or never, if cfg_no_rsp)
    initial begin : mem_model
        int          m_phase;
        int          m_cnt;
        int          m_stray_done;
        logic [31:0] m_addr;
        m_phase = 0; m_cnt = 0; m_stray_done = 0; m_addr = 32'h0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; mem_rsp_err = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; mem_rsp_err = 1'b0;
            if (rst) begin
                m_phase = 0; m_cnt = 0;
            end else if (m_phase == 0) begin
                if (mem_req_valid === 1'b1) begin
                    if (m_cnt >= cfg_ready_wait) begin
                        mem_req_ready = 1'b1;
                        m_addr  = mem_req_addr;
                        m_cnt   = 0;
                        m_phase = cfg_no_rsp ? 0 : 1;
                    end else begin
                        m_cnt++;
                    end
                end
            end else begin
                if (m_cnt >= cfg_rsp_wait) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = cfg_fixed_en ? cfg_rsp_data : mem_f(m_addr);
                    mem_rsp_err   = cfg_rsp_err;
                    m_phase = 0; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (stray_cnt != m_stray_done) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 32'hBAD0_BAD0;
                mem_rsp_err   = 1'b1;
                m_stray_done++;
            end
        end
    end

    // Scoreboard: compare response pulses and bus requests as they appear
    always @(negedge clk) begin : monitor
        rsp_t e;
        req_t q;
        if (if_rsp_valid === 1'b1 || lsu_rsp_valid === 1'b1) begin
            check_val("rsp_no_accept", {62'd0, if_req_ready, lsu_req_ready}, 64'd0);
            if (exp_rsp_q.size() == 0) begin
                check_val("rsp_unexpected", {62'd0, if_rsp_valid, lsu_rsp_valid}, 64'd0);
            end else begin
                e = exp_rsp_q.pop_front();
                check_val("rsp_owner", {62'd0, if_rsp_valid, lsu_rsp_valid}, e.lsu ? 64'd1 : 64'd2);
                if (e.cmp_data)
                    check_val("rsp_data", e.lsu ? lsu_rsp_data : if_rsp_data, e.data);
                check_val("rsp_err", e.lsu ? lsu_rsp_err : if_rsp_err, e.err);
                if (e.lat >= 0)
                    check_val("rsp_latency", cyc - last_acc, e.lat);
            end
        end
        if (mem_req_valid === 1'b1) begin
            if (exp_req_q.size() == 0) begin
                check_val("req_unexpected", mem_req_valid, 64'd0);
            end else begin
                q = exp_req_q[0];
                check_val("req_addr", mem_req_addr, q.addr);
                check_val("req_ctl", {mem_req_wen, q.cmp_wdata ? mem_req_wdata : 32'h0, mem_req_wmask},
                          {q.wen, q.cmp_wdata ? q.wdata : 32'h0, q.wmask});
                if (mem_req_ready === 1'b1) void'(exp_req_q.pop_front());
            end
        end
    end

    task automatic if_send(input logic [31:0] a);
        bit got;
        got = 0;
        if_req_valid = 1'b1;
        if_req_addr  = a;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (if_req_ready === 1'b1) begin
                got = 1;
                last_acc = cyc;
            end
            tick();
        end
        if_req_valid = 1'b0;
        if (!got) check_val("if_req_timeout", 64'd0, 64'd1);
    endtask

    task automatic lsu_send(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [3:0] m);
        bit got;
        got = 0;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = a;
        lsu_req_wen   = w;
        lsu_req_wdata = d;
        lsu_req_wmask = m;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (lsu_req_ready === 1'b1) begin
                got = 1;
                last_acc = cyc;
            end
            tick();
        end
        lsu_req_valid = 1'b0;
        if (!got) check_val("lsu_req_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && exp_rsp_q.size() == 0) done = 1;
        end
        tick();
        if (!done) check_val("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin : stim
        rst = 1'b1;
        if_req_valid = 1'b0; if_req_addr = 32'h0;
        lsu_req_valid = 1'b0; lsu_req_addr = 32'h0; lsu_req_wen = 1'b0;
        lsu_req_wdata = 32'h0; lsu_req_wmask = 4'h0;
        repeat (3) tick();
        rst = 1'b0;

        // reset state
        @(negedge clk);
        check_val("rst_busy", busy, 64'd0);
        check_val("rst_mem_valid", mem_req_valid, 64'd0);
        check_val("rst_mem_addr", mem_req_addr, 64'd0);
        check_val("rst_mem_ctl", {mem_req_wen, mem_req_wdata, mem_req_wmask}, 64'd0);
        check_val("rst_ready", {if_req_ready, lsu_req_ready}, 64'd0);
        check_val("rst_rsp_valid", {if_rsp_valid, lsu_rsp_valid}, 64'd0);
        tick();

        // IF read, reply two cycles after the bus handshake
        cfg_ready_wait = 0; cfg_rsp_wait = 1; cfg_fixed_en = 1; cfg_rsp_data = 32'hDEAD_BEEF;
        push_req(32'h100, 0, 32'h0, 4'h0, 0);
        push_rsp(0, 32'hDEAD_BEEF, 0, 3, 1);
        if_send(32'h100);
        wait_idle();

        // both requesters held together
        cfg_rsp_wait = 0; cfg_fixed_en = 0;
`ifdef CORE_MEM_ARB_RR_EN
        push_req(32'h1000, 0, 32'h0, 4'h0, 1); push_rsp(1, mem_f(32'h1000), 0, -1, 1);
        push_req(32'h0200, 0, 32'h0, 4'h0, 0); push_rsp(0, mem_f(32'h0200), 0, -1, 1);
        push_req(32'h1004, 0, 32'h0, 4'h0, 1); push_rsp(1, mem_f(32'h1004), 0, -1, 1);
`else
        push_req(32'h1000, 0, 32'h0, 4'h0, 1); push_rsp(1, mem_f(32'h1000), 0, -1, 1);
        push_req(32'h1004, 0, 32'h0, 4'h0, 1); push_rsp(1, mem_f(32'h1004), 0, -1, 1);
        push_req(32'h0200, 0, 32'h0, 4'h0, 0); push_rsp(0, mem_f(32'h0200), 0, -1, 1);
`endif
        fork
            begin
                lsu_send(32'h1000, 0, 32'h0, 4'h0);
                lsu_send(32'h1004, 0, 32'h0, 4'h0);
            end
            if_send(32'h0200);
        join
        wait_idle();

        // store held off by memory for 5 cycles, with a stray reply during REQ
        cfg_ready_wait = 5; cfg_rsp_wait = 0;
        push_req(32'h2000, 1, 32'h1122_3344, 4'b0011, 1);
        push_rsp(1, 32'h0, 0, -1, 0);
        lsu_send(32'h2000, 1, 32'h1122_3344, 4'b0011);
        tick();
        stray_cnt++;
        wait_idle();

        // watchdog: no reply, error on the fourth RESP cycle
        cfg_ready_wait = 0; cfg_no_rsp = 1;
        push_req(32'h3000, 0, 32'h0, 4'h0, 1);
        push_rsp(1, 32'h0, 1, 1 + 1 + c_tmo - 1 + 1 - 1 + 0, 1);
        lsu_send(32'h3000, 0, 32'h0, 4'h0);
        wait_idle();
        cfg_no_rsp = 0;
        stray_cnt++;
        tick(); tick();
        @(negedge clk);
        check_val("stray_busy", busy, 64'd0);
        tick();

        // bus error on IF read
        cfg_fixed_en = 1; cfg_rsp_data = 32'h0BAD_F00D; cfg_rsp_err = 1; cfg_rsp_wait = 2;
        push_req(32'h500, 0, 32'h0, 4'h0, 0);
        push_rsp(0, 32'h0BAD_F00D, 1, -1, 1);
        if_send(32'h500);
        wait_idle();
        cfg_fixed_en = 0; cfg_rsp_err = 0; cfg_rsp_wait = 0;

        // reset while waiting in RESP, with a reply landing in the reset cycle
        cfg_no_rsp = 1;
        push_req(32'h4000, 0, 32'h0, 4'h0, 1);
        lsu_send(32'h4000, 0, 32'h0, 4'h0);
        tick();
        tick();
        rst = 1'b1;
        stray_cnt++;
        tick();
        rst = 1'b0;
        cfg_no_rsp = 0;
        @(negedge clk);
        check_val("rrst_busy", busy, 64'd0);
        check_val("rrst_valids", {mem_req_valid, if_rsp_valid, lsu_rsp_valid}, 64'd0);
        tick();

        // fresh request after reset
        push_req(32'h600, 0, 32'h0, 4'h0, 0);
        push_rsp(0, mem_f(32'h600), 0, 2, 1);
        if_send(32'h600);
        wait_idle();

        check_val("rsp_drain", exp_rsp_q.size(), 64'd0);
        check_val("req_drain", exp_req_q.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish got=running exp=done");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
